fc_acc_tx: RTL



---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_acc_tx_if.sv | 23 ++
 rtl/fc_requant.sv | 29 ++
 rtl/fc_acc_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC accumulate/transmit stage.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_HEAD,
        S_DATA,
        S_TAIL
    } fc_acc_state_t;

    localparam int DEF_DATA_WIDTH = 8;

    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int DEF_SAT_MAX = sat_hi(DEF_DATA_WIDTH);
    localparam int DEF_SAT_MIN = sat_lo(DEF_DATA_WIDTH);

endpackage

// File: rtl/fc_acc_tx_if.sv
// Partial-sum input handshake plus the ready-less result stream to the activation unit.
interface fc_acc_tx_if #(
    parameter int PSUM_WIDTH = 20,
    parameter int DATA_WIDTH = 8
);
    logic                         psum_valid_i;
    logic                         psum_ready_o;
    logic signed [PSUM_WIDTH-1:0] psum_i;
    logic                         psum_last_i;
    logic                         acc_valid_o;
    logic                         acc_last_o;
    logic signed [DATA_WIDTH-1:0] acc_result_o;

    modport master (
        output psum_valid_i, psum_i, psum_last_i,
        input  psum_ready_o, acc_valid_o, acc_last_o, acc_result_o
    );

    modport slave (
        input  psum_valid_i, psum_i, psum_last_i,
        output psum_ready_o, acc_valid_o, acc_last_o, acc_result_o
    );
endinterface

// File: rtl/fc_requant.sv
// Round-half-up arithmetic right shift followed by saturation to DATA_WIDTH.
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH  = 28,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  x_i,
    input  logic        [4:0]            shift_i,
    output logic signed [DATA_WIDTH-1:0] y_o
);
    localparam int W = ACC_WIDTH + 1;
    localparam logic signed [W-1:0] HI = W'(sat_hi(DATA_WIDTH));
    localparam logic signed [W-1:0] LO = W'(sat_lo(DATA_WIDTH));

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] y;

    always_comb begin
        x_ext = W'(x_i);
        rnd   = (shift_i == 5'd0) ? '0 : (W'(1) << (shift_i - 5'd1));
        // One extra bit keeps the rounding add from overflowing.
        y     = (x_ext + rnd) >>> shift_i;
        if (y > HI)      y_o = HI[DATA_WIDTH-1:0];
        else if (y < LO) y_o = LO[DATA_WIDTH-1:0];
        else             y_o = y[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/fc_acc_tx.sv
// Accumulates K tile passes of partial sums, then streams head/data/tail to the activation unit.
module fc_acc_tx
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = 20,
    parameter int ACC_WIDTH  = 28,
    parameter int N_OUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    fc_acc_tx_if.slave        bus,
    input  logic [7:0]        cfg_k_tiles_i,
    input  logic [4:0]        cfg_shift_i,
    output logic              busy_o,
    output logic              err_o
);
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    fc_acc_state_t               state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d, cur_idx;
    logic [7:0]                  pass_q, pass_d, cur_pass;
    logic [7:0]                  k_q, k_d, cur_k;
    logic [4:0]                  shift_q, shift_d;
    logic                        err_q, err_d;
    logic                        acc_valid_q, acc_valid_d;
    logic                        acc_last_q, acc_last_d;
    logic signed [DATA_WIDTH-1:0] acc_result_q, acc_result_d, rq_y;
    logic signed [ACC_WIDTH-1:0] buf_q [N_OUT];
    logic signed [PSUM_WIDTH-1:0] psum;
    logic signed [ACC_WIDTH-1:0] wr_val;
    logic                        idle, ready, accept, end_pass;

    assign psum   = bus.psum_i;
    assign idle   = (state_q == S_IDLE);
    assign ready  = idle || (state_q == S_ACCUM);
    assign accept = bus.psum_valid_i && ready;

    // The first beat of a frame is handled as entry 0 of pass 0 with fresh cfg.
    assign cur_idx  = idle ? '0 : idx_q;
    assign cur_pass = idle ? 8'd0 : pass_q;
    assign cur_k    = idle ? ((cfg_k_tiles_i == 8'd0) ? 8'd1 : cfg_k_tiles_i) : k_q;
    assign end_pass = (cur_idx == LAST_IDX);
    assign wr_val   = (cur_pass == 8'd0) ? ACC_WIDTH'(psum)
                                         : buf_q[cur_idx] + ACC_WIDTH'(psum);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        k_d     = k_q;
        shift_d = shift_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (idle) begin
                        k_d     = cur_k;
                        shift_d = cfg_shift_i;
                    end
                    if (bus.psum_last_i != end_pass) err_d = 1'b1;
                    if (end_pass) begin
                        idx_d   = '0;
                        pass_d  = cur_pass + 8'd1;
                        state_d = (cur_pass == cur_k - 8'd1) ? S_HEAD : S_ACCUM;
                    end else begin
                        idx_d   = cur_idx + 1'b1;
                        pass_d  = cur_pass;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HEAD: begin
                state_d = S_DATA;
                idx_d   = '0;
            end
            S_DATA: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_TAIL;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_TAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        acc_valid_d  = (state_d == S_HEAD) || (state_d == S_DATA) || (state_d == S_TAIL);
        acc_last_d   = (state_d == S_TAIL);
        acc_result_d = (state_d == S_DATA) ? rq_y : '0;
    end

    fc_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rq (
        .x_i     (buf_q[idx_d]),
        .shift_i (shift_q),
        .y_o     (rq_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pass_q       <= '0;
            k_q          <= 8'd1;
            shift_q      <= '0;
            err_q        <= 1'b0;
            acc_valid_q  <= 1'b0;
            acc_last_q   <= 1'b0;
            acc_result_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            k_q          <= k_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            acc_valid_q  <= acc_valid_d;
            acc_last_q   <= acc_last_d;
            acc_result_q <= acc_result_d;
        end
    end

    // Pass 0 overwrites, so stale contents never need clearing.
    always_ff @(posedge clk) begin
        if (accept) buf_q[cur_idx] <= wr_val;
    end

    assign bus.psum_ready_o = ready;
    assign bus.acc_valid_o  = acc_valid_q;
    assign bus.acc_last_o   = acc_last_q;
    assign bus.acc_result_o = acc_result_q;
    assign busy_o           = !idle;
    assign err_o            = err_q;
endmodule
